load_mem_unit: RTL and testbench

- Downstream consumer of load_buffer: receives the issued load (read_mem, load_address, load_rob_tag) and owns the single outstanding load to main memory.
- Drives the tagged memory bus request, waits for the tagged response, then extracts and extends the requested byte/half/word.
- Broadcasts the result on the CDB with the load's ROB tag.
- Drives mem_busy back to load_buffer so that only one load is in flight.

---
 rtl/load_mem_if.sv | 43 ++++
 rtl/load_mem_unit.sv | 133 +++++++++++++
 tb/tb_load_mem_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_mem_if.sv
// Signal bundle between load_mem_unit and its neighbours: the load_buffer
// issue port, the tagged main-memory bus and the CDB broadcast port.
interface load_mem_if #(
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 5,
    parameter int MEM_TAG_W   = 4
);
    logic                   read_mem;
    logic [XLEN-1:0]        load_address;
    logic [ROB_TAG_LEN-1:0] load_rob_tag;
    logic [2:0]             load_func;
    logic                   squash;
    logic                   mem_busy;

    logic [1:0]             proc2mem_command;
    logic [XLEN-1:0]        proc2mem_addr;
    logic [MEM_TAG_W-1:0]   mem2proc_response;
    logic [63:0]            mem2proc_data;
    logic [MEM_TAG_W-1:0]   mem2proc_tag;

    logic                   cdb_req;
    logic                   cdb_grant;
    logic [XLEN-1:0]        cdb_value;
    logic [ROB_TAG_LEN-1:0] cdb_tag;

    // Handshakes: a load is accepted when read_mem is high while mem_busy is
    // low; a memory request is accepted when mem2proc_response is nonzero in
    // a cycle where proc2mem_command is BUS_LOAD; a CDB result completes when
    // cdb_grant is high while cdb_req is high.
    modport slave (
        input  read_mem, load_address, load_rob_tag, load_func, squash,
        input  mem2proc_response, mem2proc_data, mem2proc_tag, cdb_grant,
        output mem_busy, proc2mem_command, proc2mem_addr,
        output cdb_req, cdb_value, cdb_tag
    );

    modport master (
        output read_mem, load_address, load_rob_tag, load_func, squash,
        output mem2proc_response, mem2proc_data, mem2proc_tag, cdb_grant,
        input  mem_busy, proc2mem_command, proc2mem_addr,
        input  cdb_req, cdb_value, cdb_tag
    );
endinterface

// File: rtl/load_mem_unit.sv
// Single-outstanding load engine: issues a tagged memory read, waits for the
// matching response, extracts/extends the byte, half or word and broadcasts it on the CDB.
module load_mem_unit #(
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 5,
    parameter int MEM_TAG_W   = 4
) (
    input  logic       clock,
    input  logic       reset,
    load_mem_if.slave  bus,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_BCAST = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic [ROB_TAG_LEN-1:0] rob_tag_q, rob_tag_d;
    logic [2:0]             func_q, func_d;
    logic [MEM_TAG_W-1:0]   mem_tag_q, mem_tag_d;
    logic [XLEN-1:0]        cdb_value_q, cdb_value_d;
    logic [ROB_TAG_LEN-1:0] cdb_tag_q, cdb_tag_d;

    logic                   tag_hit;
    logic [31:0]            word_sel;
    logic [15:0]            half_sel;
    logic [7:0]             byte_sel;
    logic [XLEN-1:0]        load_value;

    // Tag 0 means "no transaction", so it can never complete a load.
    assign tag_hit = (bus.mem2proc_tag == mem_tag_q) && (mem_tag_q != '0);

    always_comb begin
        word_sel   = addr_q[2] ? bus.mem2proc_data[63:32] : bus.mem2proc_data[31:0];
        half_sel   = bus.mem2proc_data[{addr_q[2:1], 4'b0000} +: 16];
        byte_sel   = bus.mem2proc_data[{addr_q[2:0], 3'b000} +: 8];
        load_value = XLEN'(word_sel);
        case (func_q)
            3'b000:  load_value = XLEN'($signed(byte_sel));
            3'b001:  load_value = XLEN'($signed(half_sel));
            3'b100:  load_value = XLEN'(byte_sel);
            3'b101:  load_value = XLEN'(half_sel);
            default: load_value = XLEN'(word_sel);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rob_tag_d   = rob_tag_q;
        func_d      = func_q;
        mem_tag_d   = mem_tag_q;
        cdb_value_d = cdb_value_q;
        cdb_tag_d   = cdb_tag_q;
        case (state_q)
            S_IDLE: begin
                if (bus.read_mem && !bus.squash) begin
                    addr_d    = bus.load_address;
                    rob_tag_d = bus.load_rob_tag;
                    func_d    = bus.load_func;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                // An accepted request must be drained even when squashed.
                if (bus.mem2proc_response != '0) begin
                    mem_tag_d = bus.mem2proc_response;
                    state_d   = bus.squash ? S_DRAIN : S_WAIT;
                end else if (bus.squash) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (tag_hit) begin
                    if (bus.squash) begin
                        state_d = S_IDLE;
                    end else begin
                        cdb_value_d = load_value;
                        cdb_tag_d   = rob_tag_q;
                        state_d     = S_BCAST;
                    end
                end else if (bus.squash) begin
                    state_d = S_DRAIN;
                end
            end
            S_BCAST: begin
                if (bus.squash || bus.cdb_grant) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (tag_hit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_busy         = (state_q != S_IDLE);
        bus.proc2mem_command = (state_q == S_REQ) ? BUS_LOAD : BUS_NONE;
        bus.proc2mem_addr    = {addr_q[XLEN-1:3], 3'b000};
        bus.cdb_req          = (state_q == S_BCAST) && !bus.squash;
        bus.cdb_value        = cdb_value_q;
        bus.cdb_tag          = cdb_tag_q;
        dbg_state            = state_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rob_tag_q   <= '0;
            func_q      <= '0;
            mem_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rob_tag_q   <= rob_tag_d;
            func_q      <= func_d;
            mem_tag_q   <= mem_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_tag_q   <= cdb_tag_d;
        end
    end
endmodule

// File: tb/tb_load_mem_unit.sv
// Directed bench for load_mem_unit: inputs change on the falling edge,
// outputs are checked shortly after, against hand-computed values.
module tb_load_mem_unit;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_BCAST = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic       clock;
  logic       reset;
  logic [2:0] dbg_state;
  int         n_vec;
  int         n_err;

  load_mem_if #(.XLEN(32), .ROB_TAG_LEN(5), .MEM_TAG_W(4)) bus ();

  load_mem_unit #(.XLEN(32), .ROB_TAG_LEN(5), .MEM_TAG_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic issue(input logic [31:0] addr, input logic [4:0] rtag, input logic [2:0] func);
    bus.read_mem     = 1'b1;
    bus.load_address = addr;
    bus.load_rob_tag = rtag;
    bus.load_func    = func;
    tick();
    bus.read_mem = 1'b0;
    #1;
  endtask

  // Full load with immediate acceptance and a one-cycle idle gap before the response.
  task automatic run_load(input string name, input logic [31:0] addr, input logic [4:0] rtag,
                          input logic [2:0] func, input logic [3:0] mtag,
                          input logic [63:0] data, input logic [31:0] exp_val);
    issue(addr, rtag, func);
    check({name, "_cmd"}, bus.proc2mem_command, 2'd1);
    check({name, "_addr"}, bus.proc2mem_addr, addr & 32'hFFFF_FFF8);
    bus.mem2proc_response = mtag;
    tick();
    bus.mem2proc_response = 4'd0;
    #1;
    check({name, "_wait"}, dbg_state, ST_WAIT);
    tick();
    bus.mem2proc_tag  = mtag;
    bus.mem2proc_data = data;
    #1;
    check({name, "_noreq"}, bus.cdb_req, 1'b0);
    tick();
    bus.mem2proc_tag = 4'd0;
    #1;
    check({name, "_req"}, bus.cdb_req, 1'b1);
    check({name, "_val"}, bus.cdb_value, exp_val);
    check({name, "_tag"}, bus.cdb_tag, rtag);
    bus.cdb_grant = 1'b1;
    tick();
    bus.cdb_grant = 1'b0;
    #1;
    check({name, "_idle"}, bus.mem_busy, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.read_mem = 1'b0;
    bus.load_address = '0;
    bus.load_rob_tag = '0;
    bus.load_func = '0;
    bus.squash = 1'b0;
    bus.mem2proc_response = '0;
    bus.mem2proc_data = '0;
    bus.mem2proc_tag = '0;
    bus.cdb_grant = 1'b0;
    repeat (2) tick();
    check("rst_busy", bus.mem_busy, 1'b0);
    check("rst_cmd", bus.proc2mem_command, 2'd0);
    check("rst_addr", bus.proc2mem_addr, 32'd0);
    check("rst_req", bus.cdb_req, 1'b0);
    check("rst_val", bus.cdb_value, 32'd0);
    check("rst_tag", bus.cdb_tag, 5'd0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b1;
    tick();

    // 1: basic LW from the upper word
    run_load("lw", 32'h1004, 5'd3, 3'b010, 4'd2, 64'hAABBCCDD_11223344, 32'hAABBCCDD);
    check("lw_hold", bus.cdb_value, 32'hAABBCCDD);

    // 2: extraction and extension
    run_load("lb", 32'h2007, 5'd4, 3'b000, 4'd1, 64'h80112233_44556677, 32'hFFFFFF80);
    run_load("lbu", 32'h2007, 5'd4, 3'b100, 4'd1, 64'h80112233_44556677, 32'h00000080);
    run_load("lh", 32'h2002, 5'd5, 3'b001, 4'd3, 64'h00000000_80014455, 32'hFFFF8001);
    run_load("lhu", 32'h2006, 5'd6, 3'b101, 4'd7, 64'hC0DE0000_00000000, 32'h0000C0DE);
    run_load("f011", 32'h2004, 5'd7, 3'b011, 4'd9, 64'h12345678_9ABCDEF0, 32'h12345678);
    run_load("lwmis", 32'h2003, 5'd8, 3'b010, 4'd15, 64'h12345678_9ABCDEF0, 32'h9ABCDEF0);

    // squash on an issue cycle drops the load
    bus.squash = 1'b1;
    issue(32'h5000, 5'd1, 3'b010);
    bus.squash = 1'b0;
    check("sq_issue", dbg_state, ST_IDLE);

    // 3: memory rejects three times, stray tag ignored
    issue(32'h3010, 5'd9, 3'b010);
    for (int i = 0; i < 4; i++) begin
      check("rej_cmd", bus.proc2mem_command, 2'd1);
      check("rej_addr", bus.proc2mem_addr, 32'h3010);
      if (i == 3) bus.mem2proc_response = 4'd5;
      tick();
      #1;
    end
    bus.mem2proc_response = 4'd0;
    check("rej_wait", dbg_state, ST_WAIT);
    check("rej_cmd0", bus.proc2mem_command, 2'd0);
    bus.mem2proc_tag = 4'd4;
    bus.mem2proc_data = 64'h0;
    tick();
    #1;
    check("stray_wait", dbg_state, ST_WAIT);
    check("stray_req", bus.cdb_req, 1'b0);
    bus.mem2proc_tag = 4'd5;
    bus.mem2proc_data = 64'h00000000_CAFEF00D;
    tick();
    bus.mem2proc_tag = 4'd0;
    #1;
    check("rej_val", bus.cdb_value, 32'hCAFEF00D);
    check("rej_rtag", bus.cdb_tag, 5'd9);

    // 4: CDB back-pressure with a new read_mem ignored meanwhile
    bus.read_mem = 1'b1;
    bus.load_address = 32'h7770;
    bus.load_rob_tag = 5'd20;
    for (int i = 0; i < 4; i++) begin
      check("bp_req", bus.cdb_req, 1'b1);
      check("bp_val", bus.cdb_value, 32'hCAFEF00D);
      check("bp_tag", bus.cdb_tag, 5'd9);
      check("bp_busy", bus.mem_busy, 1'b1);
      tick();
      #1;
    end
    bus.read_mem = 1'b0;
    bus.cdb_grant = 1'b1;
    tick();
    bus.cdb_grant = 1'b0;
    #1;
    check("bp_idle", dbg_state, ST_IDLE);

    // 5: squash in WAIT -> DRAIN -> IDLE on tag 6
    issue(32'h4000, 5'd11, 3'b010);
    bus.mem2proc_response = 4'd6;
    tick();
    bus.mem2proc_response = 4'd0;
    bus.squash = 1'b1;
    tick();
    bus.squash = 1'b0;
    #1;
    check("dr_state", dbg_state, ST_DRAIN);
    check("dr_busy", bus.mem_busy, 1'b1);
    check("dr_req", bus.cdb_req, 1'b0);
    check("dr_cmd", bus.proc2mem_command, 2'd0);
    bus.squash = 1'b1;
    bus.mem2proc_tag = 4'd6;
    bus.mem2proc_data = 64'h11111111_22222222;
    tick();
    bus.squash = 1'b0;
    bus.mem2proc_tag = 4'd0;
    #1;
    check("dr_idle", dbg_state, ST_IDLE);
    check("dr_noval", bus.cdb_value, 32'hCAFEF00D);
    run_load("post_dr", 32'h4008, 5'd12, 3'b010, 4'd2, 64'h00000000_0BADBEEF, 32'h0BADBEEF);

    // squash in REQ with and without acceptance
    issue(32'h6000, 5'd13, 3'b010);
    bus.squash = 1'b1;
    tick();
    bus.squash = 1'b0;
    #1;
    check("sq_req0", dbg_state, ST_IDLE);
    issue(32'h6000, 5'd13, 3'b010);
    bus.squash = 1'b1;
    bus.mem2proc_response = 4'd8;
    tick();
    bus.squash = 1'b0;
    bus.mem2proc_response = 4'd0;
    #1;
    check("sq_req1", dbg_state, ST_DRAIN);
    bus.mem2proc_tag = 4'd8;
    tick();
    bus.mem2proc_tag = 4'd0;
    #1;
    check("sq_req1_idle", dbg_state, ST_IDLE);

    // 6: squash together with grant in BCAST
    issue(32'h8004, 5'd14, 3'b010);
    bus.mem2proc_response = 4'd3;
    tick();
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag = 4'd3;
    bus.mem2proc_data = 64'h13572468_00000000;
    tick();
    bus.mem2proc_tag = 4'd0;
    #1;
    check("sqb_req_pre", bus.cdb_req, 1'b1);
    bus.squash = 1'b1;
    bus.cdb_grant = 1'b1;
    #1;
    check("sqb_req", bus.cdb_req, 1'b0);
    tick();
    bus.squash = 1'b0;
    bus.cdb_grant = 1'b0;
    #1;
    check("sqb_idle", dbg_state, ST_IDLE);

    // asynchronous reset during REQ
    issue(32'h9008, 5'd15, 3'b010);
    check("ar_pre", dbg_state, ST_REQ);
    #2;
    reset = 1'b0;
    #1;
    check("ar_busy", bus.mem_busy, 1'b0);
    check("ar_cmd", bus.proc2mem_command, 2'd0);
    check("ar_addr", bus.proc2mem_addr, 32'd0);
    check("ar_val", bus.cdb_value, 32'd0);
    check("ar_tag", bus.cdb_tag, 5'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
